// File: rtl/osc_bank.sv
// Time-multiplexed phase-accumulator oscillator bank: one voice per clock after a frame strobe.
// Each voice produces a saw, square, triangle or LFSR-noise sample from its accumulator phase.
module osc_bank #(
   parameter int unsigned BITDEPTH    = 12,
   parameter int unsigned BITFRACTION = 8,
   parameter int unsigned INCWIDTH    = 19,
   parameter int unsigned VOICES      = 4
) (
   input  logic                         sample_clock,
   input  logic                         reset_n,
   input  logic                         sample_strobe,
   input  logic [VOICES*INCWIDTH-1:0]   increment,
   input  logic [VOICES*2-1:0]          waveform,
   input  logic [VOICES*BITDEPTH-1:0]   pulse_width,
   input  logic [VOICES-1:0]            sync_reset,
   output logic [VOICES*BITDEPTH-1:0]   out,
   output logic                         busy,
   output logic                         done
);

   localparam int unsigned ACCW = BITDEPTH + BITFRACTION;
   localparam int unsigned SUMW = ACCW + 1;
   localparam int unsigned CHW  = (VOICES > 1) ? $clog2(VOICES) : 1;
   localparam logic [CHW-1:0] LAST_CH = CHW'(VOICES - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q, state_d;
   logic [CHW-1:0]    ch_q, ch_d;
   logic              busy_d, done_d, proc_en;
   logic [ACCW-1:0]   acc_q [VOICES];
   logic [VOICES-1:0] sync_q;
   logic [15:0]       lfsr_q;

   logic [ACCW-1:0]     acc_sel;
   logic [INCWIDTH-1:0] inc_sel;
   logic [1:0]          wave_sel;
   logic [BITDEPTH-1:0] pw_sel;
   logic                sync_sel;
   logic [SUMW-1:0]     sum;
   logic                carry;
   logic [ACCW-1:0]     acc_next;
   logic [BITDEPTH-1:0] phase, tri_low, noise_val, wave_val;
   logic                load_en;

   // Frame sequencer state register
   always_ff @(posedge sample_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ch_q    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

   // Frame sequencer next-state: strobes are only accepted from IDLE
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      proc_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sample_strobe) begin
               state_d = RUN;
               ch_d    = '0;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            proc_en = 1'b1;
            if (ch_q == LAST_CH) begin
               state_d = IDLE;
               ch_d    = '0;
               done_d  = 1'b1;
            end else begin
               ch_d   = ch_q + CHW'(1);
               busy_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Select the controls and state of the voice being processed
   always_comb begin
      acc_sel  = '0;
      inc_sel  = '0;
      wave_sel = '0;
      pw_sel   = '0;
      sync_sel = 1'b0;
      for (int unsigned k = 0; k < VOICES; k++) begin
         if (ch_q == CHW'(k)) begin
            acc_sel  = acc_q[k];
            inc_sel  = increment[k*INCWIDTH +: INCWIDTH];
            wave_sel = waveform[k*2 +: 2];
            pw_sel   = pulse_width[k*BITDEPTH +: BITDEPTH];
            sync_sel = sync_q[k] | sync_reset[k];
         end
      end
   end

   assign sum      = {1'b0, acc_sel} + SUMW'(inc_sel);
   assign carry    = sum[ACCW];
   assign acc_next = sync_sel ? '0 : sum[ACCW-1:0];
   assign phase    = acc_next[ACCW-1 -: BITDEPTH];
   assign tri_low  = {phase[BITDEPTH-2:0], 1'b0};

   if (BITDEPTH <= 16) begin : g_noise_narrow
      assign noise_val = lfsr_q[BITDEPTH-1:0];
   end else begin : g_noise_wide
      assign noise_val = BITDEPTH'(lfsr_q);
   end

   // Waveform shaping; noise only refreshes when the accumulator wraps
   always_comb begin
      wave_val = phase;
      load_en  = proc_en;
      unique case (wave_sel)
         2'b00: wave_val = phase;
         2'b01: wave_val = (phase < pw_sel) ? '1 : '0;
         2'b10: wave_val = phase[BITDEPTH-1] ? ~tri_low : tri_low;
         default: begin
            wave_val = noise_val;
            load_en  = proc_en & carry & ~sync_sel;
         end
      endcase
   end

   // Per-voice accumulator, sticky sync request and output sample
   always_ff @(posedge sample_clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned k = 0; k < VOICES; k++) acc_q[k] <= '0;
         sync_q <= '0;
         out    <= '0;
      end else begin
         for (int unsigned k = 0; k < VOICES; k++) begin
            if (proc_en && (ch_q == CHW'(k))) begin
               acc_q[k]  <= acc_next;
               sync_q[k] <= 1'b0;
               if (load_en) out[k*BITDEPTH +: BITDEPTH] <= wave_val;
            end else begin
               sync_q[k] <= sync_q[k] | sync_reset[k];
            end
         end
      end
   end

   // Shared noise source, free-running every clock
   always_ff @(posedge sample_clock or negedge reset_n) begin
      if (!reset_n) lfsr_q <= 16'hACE1;
      else          lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

endmodule

// File: tb/tb_osc_bank.sv
// Randomized and directed bench for osc_bank against a frame-level behavioural model.
module tb_osc_bank;

   localparam int BD    = 12;
   localparam int FRAC  = 8;
   localparam int INCW  = 19;
   localparam int NV    = 4;
   localparam int ACC_MOD = 1 << (BD + FRAC);

   logic              sample_clock, reset_n, sample_strobe;
   logic [NV*INCW-1:0] increment;
   logic [NV*2-1:0]    waveform;
   logic [NV*BD-1:0]   pulse_width;
   logic [NV-1:0]      sync_reset;
   logic [NV*BD-1:0]   out;
   logic               busy, done;

   int vectors = 0;
   int miscompares = 0;

   // behavioural model state
   int unsigned       m_acc [NV];
   bit [NV-1:0]       m_pend;
   int                m_pos;
   logic [NV*BD-1:0]  exp_out;
   logic              m_busy, m_done;
   logic [15:0]       m_lfsr;

   osc_bank #(.BITDEPTH(BD), .BITFRACTION(FRAC), .INCWIDTH(INCW), .VOICES(NV)) dut (
      .sample_clock(sample_clock), .reset_n(reset_n), .sample_strobe(sample_strobe),
      .increment(increment), .waveform(waveform), .pulse_width(pulse_width),
      .sync_reset(sync_reset), .out(out), .busy(busy), .done(done));

   initial begin
      sample_clock = 1'b0;
      forever #5 sample_clock = ~sample_clock;
   end

   task automatic model_reset();
      for (int k = 0; k < NV; k++) m_acc[k] = 0;
      m_pend  = '0;
      m_pos   = -1;
      exp_out = '0;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_lfsr  = 16'hACE1;
   endtask

   // One clock edge: advance the model with the inputs seen at that edge, then settle
   task automatic cyc();
      logic [15:0] l0;
      int unsigned s, pi, lo, w;
      bit wrap, syn;
      int v;
      @(posedge sample_clock);
      if (reset_n) begin
         l0 = m_lfsr;
         m_done = 1'b0;
         v = m_pos;
         for (int k = 0; k < NV; k++)
            if (k != v) m_pend[k] = m_pend[k] | sync_reset[k];
         if (v >= 0) begin
            s    = m_acc[v] + int'(increment[v*INCW +: INCW]);
            wrap = (s >= ACC_MOD);
            syn  = m_pend[v] | sync_reset[v];
            m_acc[v] = syn ? 0 : s % ACC_MOD;
            m_pend[v] = 1'b0;
            pi = m_acc[v] >> FRAC;
            case (waveform[2*v +: 2])
               2'b00: exp_out[v*BD +: BD] = BD'(pi);
               2'b01: exp_out[v*BD +: BD] = (pi < int'(pulse_width[v*BD +: BD])) ? 12'hFFF : 12'h000;
               2'b10: begin
                  lo = (pi * 2) % 4096;
                  w  = (pi >= 2048) ? 4095 - lo : lo;
                  exp_out[v*BD +: BD] = BD'(w);
               end
               default: if (wrap && !syn) exp_out[v*BD +: BD] = l0[11:0];
            endcase
            m_pos = m_pos + 1;
            if (m_pos == NV) begin
               m_pos  = -1;
               m_done = 1'b1;
            end
         end else if (sample_strobe) begin
            m_pos = 0;
         end
         m_busy = (m_pos >= 0);
         m_lfsr = {l0[14:0], l0[15] ^ l0[13] ^ l0[12] ^ l0[10]};
      end
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      cyc();
      cyc();
      reset_n = 1'b1;
   endtask

   task automatic set_voice(input int v, input int unsigned inc, input logic [1:0] wf,
                            input int unsigned pw);
      increment[v*INCW +: INCW] = INCW'(inc);
      waveform[v*2 +: 2]        = wf;
      pulse_width[v*BD +: BD]   = BD'(pw);
   endtask

   task automatic test_reset();
      sample_strobe = 1'b0; sync_reset = '0;
      increment = '0; waveform = '0; pulse_width = '0;
      reset_n = 1'b0;
      #3;
      model_reset();
      vectors++;
      if (out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state out=%h busy=%b done=%b required 0/0/0", out, busy, done);
      end
      apply_reset();
      repeat (3) begin
         cyc();
         vectors++;
         if (out !== exp_out || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle out=%h exp=%h busy=%b done=%b", out, exp_out, busy, done);
         end
      end
   endtask

   task automatic test_saw();
      int dones;
      apply_reset();
      set_voice(0, 'h100, 2'b00, 0);
      for (int f = 0; f < 16; f++) begin
         dones = 0;
         for (int c = 0; c < NV + 2; c++) begin
            sample_strobe = (c == 0);
            cyc();
            if (done) dones++;
            vectors++;
            if (out !== exp_out || busy !== m_busy || done !== m_done ||
                done !== (c == NV)) begin
               miscompares++;
               $display("FAIL saw f=%0d c=%0d out=%h exp=%h busy=%b/%b done=%b/%b",
                        f, c, out, exp_out, busy, m_busy, done, m_done);
            end
         end
         vectors++;
         if (out[11:0] !== 12'(f + 1) || dones != 1) begin
            miscompares++;
            $display("FAIL saw_value f=%0d out0=%h required %h dones=%0d", f, out[11:0], f + 1, dones);
         end
      end
   endtask

   task automatic test_wrap();
      logic [11:0] want [3];
      want[0] = 12'h7FF; want[1] = 12'hFFF; want[2] = 12'h7FF;
      apply_reset();
      set_voice(1, 'h7FFFF, 2'b00, 0);
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < NV + 1; c++) begin
            sample_strobe = (c == 0);
            cyc();
            vectors++;
            if (out !== exp_out || busy !== m_busy || done !== m_done) begin
               miscompares++;
               $display("FAIL wrap f=%0d c=%0d out=%h exp=%h", f, c, out, exp_out);
            end
         end
         vectors++;
         if (out[23:12] !== want[f]) begin
            miscompares++;
            $display("FAIL wrap_value f=%0d out1=%h required %h", f, out[23:12], want[f]);
         end
      end
   endtask

   task automatic test_shapes();
      logic [11:0] sq [4];
      logic [11:0] tr [4];
      sq[0] = 12'hFFF; sq[1] = 12'h000; sq[2] = 12'h000; sq[3] = 12'hFFF;
      tr[0] = 12'h800; tr[1] = 12'hFFF; tr[2] = 12'h7FF; tr[3] = 12'h000;
      apply_reset();
      set_voice(0, 'h40000, 2'b01, 'h800);
      set_voice(1, 'h40000, 2'b10, 'h800);
      set_voice(2, 'h40000, 2'b01, 0);
      for (int f = 0; f < 4; f++) begin
         for (int c = 0; c < NV + 1; c++) begin
            sample_strobe = (c == 0);
            cyc();
            vectors++;
            if (out !== exp_out || busy !== m_busy || done !== m_done) begin
               miscompares++;
               $display("FAIL shapes f=%0d c=%0d out=%h exp=%h", f, c, out, exp_out);
            end
         end
         vectors++;
         if (out[11:0] !== sq[f] || out[23:12] !== tr[f] || out[35:24] !== 12'h000) begin
            miscompares++;
            $display("FAIL shapes_value f=%0d sq=%h/%h tri=%h/%h pw0=%h", f, out[11:0], sq[f],
                     out[23:12], tr[f], out[35:24]);
         end
      end
   endtask

   task automatic test_sync();
      logic [11:0] want [4];
      want[0] = 12'h000; want[1] = 12'h001; want[2] = 12'h000; want[3] = 12'h001;
      apply_reset();
      set_voice(2, 'h100, 2'b00, 0);
      for (int f = 0; f < 9; f++) begin
         if (f == 5) begin
            sync_reset = 4'b0100;
            cyc();
            sync_reset = '0;
         end
         for (int c = 0; c < NV + 1; c++) begin
            sample_strobe = (c == 0);
            sync_reset    = (f == 7 && c == 3) ? 4'b0100 : 4'b0000;
            cyc();
            vectors++;
            if (out !== exp_out || busy !== m_busy || done !== m_done) begin
               miscompares++;
               $display("FAIL sync f=%0d c=%0d out=%h exp=%h", f, c, out, exp_out);
            end
         end
         sync_reset = '0;
         if (f >= 5) begin
            vectors++;
            if (out[35:24] !== want[f-5]) begin
               miscompares++;
               $display("FAIL sync_value f=%0d out2=%h required %h", f, out[35:24], want[f-5]);
            end
         end
      end
   endtask

   task automatic test_control();
      int dones;
      apply_reset();
      set_voice(0, 'h1234, 2'b00, 0);
      set_voice(3, 'h5, 2'b10, 0);
      dones = 0;
      for (int c = 0; c < NV + 3; c++) begin
         sample_strobe = (c <= NV);
         cyc();
         if (done) dones++;
         vectors++;
         if (out !== exp_out || busy !== m_busy || done !== m_done) begin
            miscompares++;
            $display("FAIL strobe_in_run c=%0d out=%h exp=%h busy=%b/%b done=%b/%b",
                     c, out, exp_out, busy, m_busy, done, m_done);
         end
         if (c == NV) sample_strobe = 1'b0;
      end
      sample_strobe = 1'b0;
      repeat (NV + 2) cyc();
      vectors++;
      if (dones != 1) begin
         miscompares++;
         $display("FAIL strobe_ignored dones=%0d required 1", dones);
      end
      sample_strobe = 1'b1;
      cyc();
      sample_strobe = 1'b0;
      cyc();
      reset_n = 1'b0;
      #1;
      model_reset();
      vectors++;
      if (out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL midframe_reset out=%h busy=%b done=%b required 0/0/0", out, busy, done);
      end
      cyc();
      reset_n = 1'b1;
      for (int c = 0; c < NV + 2; c++) begin
         cyc();
         vectors++;
         if (out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL after_abort c=%0d out=%h busy=%b done=%b required 0/0/0", c, out, busy, done);
         end
      end
   endtask

   task automatic test_noise();
      logic [11:0] prev;
      int changes;
      apply_reset();
      set_voice(3, 'h7FFFF, 2'b11, 0);
      changes = 0;
      for (int f = 0; f < 8; f++) begin
         prev = out[47:36];
         for (int c = 0; c < NV + 1 + (f % 3); c++) begin
            sample_strobe = (c == 0);
            cyc();
            vectors++;
            if (out !== exp_out || busy !== m_busy || done !== m_done) begin
               miscompares++;
               $display("FAIL noise f=%0d c=%0d out=%h exp=%h", f, c, out, exp_out);
            end
         end
         if (out[47:36] !== prev) changes++;
      end
      vectors++;
      if (changes < 3) begin
         miscompares++;
         $display("FAIL noise_activity changes=%0d required at least 3", changes);
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 9) == 0)
            set_voice(int'($urandom_range(0, NV - 1)),
                      ($urandom_range(0, 3) == 0) ? 32'h7FFFF - $urandom_range(0, 255)
                                                   : $urandom_range(0, 32'h7FFFF),
                      2'($urandom_range(0, 3)), $urandom_range(0, 4095));
         sample_strobe = ($urandom_range(0, 2) == 0);
         sync_reset    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
         cyc();
         vectors++;
         if (out !== exp_out || busy !== m_busy || done !== m_done) begin
            miscompares++;
            $display("FAIL random c=%0d out=%h exp=%h busy=%b/%b done=%b/%b",
                     c, out, exp_out, busy, m_busy, done, m_done);
         end
      end
      sample_strobe = 1'b0;
      sync_reset = '0;
   endtask

   initial begin
      test_reset();
      test_saw();
      test_wrap();
      test_shapes();
      test_sync();
      test_control();
      test_noise();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
